ps2_rx: RTL

//  Host-side receiver for the PS/2-style serial link driven by a device (11-bit frame:

---
 rtl/ps2_rx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// PS/2 host receiver: synchronize, filter, deframe, valid/ready byte output.
// Optional watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          fclk;
  logic [FW-1:0] fcnt;
  logic          flip;
  logic          fall;

  state_t     state, state_d;
  logic [3:0] bcnt, bcnt_d;
  logic [9:0] sr, sr_d;
  logic [7:0] data_d;
  logic       valid_d;
  logic       perr_d, ferr_d, ovr_d, tout_d;

  assign flip = (clk_s2 != fclk) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall = flip && fclk;
  assign busy = (state != IDLE);

  // two-flop synchronizers and ps2_clk glitch filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fclk   <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      if (flip) begin
        fclk <= clk_s2;
        fcnt <= '0;
      end else if (clk_s2 != fclk) begin
        fcnt <= fcnt + 1'b1;
      end else begin
        fcnt <= '0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog, wdog_d;
  logic          wdog_hit;

  assign wdog_hit = (wdog >= WW'(TIMEOUT_CYCLES - 1));

  // watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog <= '0;
    else        wdog <= wdog_d;
  end

  // watchdog runs only between edges inside a frame and saturates
  always_comb begin
    wdog_d = '0;
    if (state == SHIFT && !fall) begin
      wdog_d = wdog_hit ? WW'(TIMEOUT_CYCLES) : wdog + 1'b1;
    end
  end
`else
  logic wdog_hit;
  assign wdog_hit = 1'b0;
`endif

  // state, shift register and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bcnt        <= '0;
      sr          <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      bcnt        <= bcnt_d;
      sr          <= sr_d;
      rx_data     <= data_d;
      rx_valid    <= valid_d;
      parity_err  <= perr_d;
      frame_err   <= ferr_d;
      overrun     <= ovr_d;
      timeout_err <= tout_d;
    end
  end

  // next state, frame check and handshake
  always_comb begin
    state_d = state;
    bcnt_d  = bcnt;
    sr_d    = sr;
    data_d  = rx_data;
    valid_d = rx_valid & ~rx_ready;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    tout_d  = 1'b0;
    unique case (state)
      IDLE: begin
        bcnt_d = '0;
        if (fall && !dat_s2) state_d = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          sr_d   = {dat_s2, sr[9:1]};
          bcnt_d = bcnt + 1'b1;
          if (bcnt == 4'd9) state_d = CHECK;
        end else if (wdog_hit) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!sr[9]) begin
          ferr_d = 1'b1;
        end else if (sr[8] != ~^sr[7:0]) begin
          perr_d = 1'b1;
        end else if (rx_valid && !rx_ready) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = sr[7:0];
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
